// File: rtl/raster_pipeline_ex0_pkg.sv
// Shared types, widths and helpers for the
// triangle setup / bbox traversal stage.
package raster_pipeline_ex0_pkg;

  localparam int FIXPT_SIZE   = 32;
  localparam int COORD_W      = 16;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_ACC_W    = 34;

  typedef logic [FIXPT_SIZE-1:0] fixpt_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    fixpt_t     u;
    fixpt_t     v;
  } attr_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    attr_t  attr;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP0,
    SETUP1,
    SETUP2,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  function automatic coord_t min3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(
    input coord_t a,
    input coord_t b,
    input coord_t c
  );
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic coord_t clip(
    input coord_t v,
    input coord_t hi
  );
    if (v < coord_t'(0)) return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/raster_pipeline_ex0_if.sv
// Triangle request / covered-pixel bundle
// between the rasterizer and its neighbours.
interface raster_pipeline_ex0_if;
  import raster_pipeline_ex0_pkg::*;

  logic    i_start;
  logic    i_stall;
  vertex_t i_v1;
  vertex_t i_v2;
  vertex_t i_v3;

  logic    o_busy;
  logic    o_done;
  logic    o_write_enable;
  coord_t  o_x;
  coord_t  o_y;
  fixpt_t  o_area;
  fixpt_t  o_e1;
  fixpt_t  o_e2;
  fixpt_t  o_e3;
  attr_t   o_v1;
  attr_t   o_v2;
  attr_t   o_v3;

  modport master (
    output i_start, i_stall,
    output i_v1, i_v2, i_v3,
    input  o_busy, o_done,
    input  o_write_enable,
    input  o_x, o_y,
    input  o_area,
    input  o_e1, o_e2, o_e3,
    input  o_v1, o_v2, o_v3
  );

  modport slave (
    input  i_start, i_stall,
    input  i_v1, i_v2, i_v3,
    output o_busy, o_done,
    output o_write_enable,
    output o_x, o_y,
    output o_area,
    output o_e1, o_e2, o_e3,
    output o_v1, o_v2, o_v3
  );

endinterface

// File: rtl/raster_pipeline_ex0_edge_walker.sv
// Incremental evaluator for one edge function:
// row-start and current-column accumulators.
module raster_pipeline_ex0_edge_walker #(
  parameter int ACC_W = 34,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    row,
  input  logic signed [ACC_W-1:0] init,
  input  logic signed [ACC_W-1:0] col_step,
  input  logic signed [ACC_W-1:0] row_step,
  output logic                    neg,
  output logic [OUT_W-1:0]        value
);

  logic signed [ACC_W-1:0] row_acc;
  logic signed [ACC_W-1:0] col_acc;
  logic signed [ACC_W-1:0] dx;
  logic signed [ACC_W-1:0] dy;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_acc <= '0;
      col_acc <= '0;
      dx      <= '0;
      dy      <= '0;
    end else begin
      unique case (1'b1)
        load: begin
          row_acc <= init;
          col_acc <= init;
          dx      <= col_step;
          dy      <= row_step;
        end
        row: begin
          row_acc <= row_acc + dy;
          col_acc <= row_acc + dy;
        end
        step: col_acc <= col_acc + dx;
        default: ;
      endcase
    end
  end

  assign neg   = col_acc[ACC_W-1];
  assign value = col_acc[OUT_W-1:0];

endmodule

// File: rtl/raster_pipeline_ex0.sv
// Triangle setup and bounding-box scan; one
// candidate pixel per cycle into EX1.
module raster_pipeline_ex0
  import raster_pipeline_ex0_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ACC_W    = DEF_ACC_W
) (
  input logic                 i_clk,
  input logic                 i_reset,
  raster_pipeline_ex0_if.slave bus
);

  typedef logic signed [COORD_W:0]  dif_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam coord_t XMAX = coord_t'(SCREEN_W-1);
  localparam coord_t YMAX = coord_t'(SCREEN_H-1);

  function automatic dif_t diff(
    input coord_t a,
    input coord_t b
  );
    return dif_t'(a) - dif_t'(b);
  endfunction

  function automatic acc_t sx(input dif_t d);
    return acc_t'(d);
  endfunction

  state_t state;
  coord_t vx [3];
  coord_t vy [3];
  coord_t xmin, xmax, ymin, ymax;
  logic   empty;
  dif_t   dx [3];
  dif_t   dy [3];
  acc_t   e_raw [3];
  acc_t   area_raw;
  fixpt_t area_q;
  coord_t x_cur, y_cur;

  logic         neg, reject;
  logic         adv, at_x, at_y;
  logic         load, step, row;
  logic [2:0]   e_neg;
  fixpt_t       e_val [3];

  assign neg    = area_raw[ACC_W-1];
  assign reject = (area_raw == '0) || empty;
  assign adv    = (state == SCAN) && !bus.i_stall;
  assign at_x   = (x_cur == xmax);
  assign at_y   = (y_cur == ymax);
  assign load   = (state == SETUP2);
  assign step   = adv && !at_x;
  assign row    = adv && at_x && !at_y;

  // Negative winding is folded into the walkers at load time.
  for (genvar k = 0; k < 3; k++) begin : g_edge
    raster_pipeline_ex0_edge_walker #(
      .ACC_W (ACC_W),
      .OUT_W (FIXPT_SIZE)
    ) u_walk (
      .clk      (i_clk),
      .rst      (i_reset),
      .load     (load),
      .step     (step),
      .row      (row),
      .init     (neg ? -e_raw[k] : e_raw[k]),
      .col_step (neg ? -sx(dx[k]) : sx(dx[k])),
      .row_step (neg ? -sx(dy[k]) : sx(dy[k])),
      .neg      (e_neg[k]),
      .value    (e_val[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      for (int k = 0; k < 3; k++) begin
        vx[k]    <= '0;
        vy[k]    <= '0;
        dx[k]    <= '0;
        dy[k]    <= '0;
        e_raw[k] <= '0;
      end
      xmin     <= '0;
      xmax     <= '0;
      ymin     <= '0;
      ymax     <= '0;
      empty    <= 1'b0;
      area_raw <= '0;
      area_q   <= '0;
      x_cur    <= '0;
      y_cur    <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_write_enable <= 1'b0;
      bus.o_x            <= '0;
      bus.o_y            <= '0;
      bus.o_area         <= '0;
      bus.o_e1           <= '0;
      bus.o_e2           <= '0;
      bus.o_e3           <= '0;
      bus.o_v1           <= '0;
      bus.o_v2           <= '0;
      bus.o_v3           <= '0;
    end else begin
      bus.o_write_enable <= 1'b0;
      bus.o_done         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            vx[0] <= bus.i_v1.x;
            vy[0] <= bus.i_v1.y;
            vx[1] <= bus.i_v2.x;
            vy[1] <= bus.i_v2.y;
            vx[2] <= bus.i_v3.x;
            vy[2] <= bus.i_v3.y;
            bus.o_v1   <= bus.i_v1.attr;
            bus.o_v2   <= bus.i_v2.attr;
            bus.o_v3   <= bus.i_v3.attr;
            bus.o_busy <= 1'b1;
            state      <= SETUP0;
          end
        end
        SETUP0: begin
          xmin  <= clip(min3(vx[0], vx[1], vx[2]), XMAX);
          xmax  <= clip(max3(vx[0], vx[1], vx[2]), XMAX);
          ymin  <= clip(min3(vy[0], vy[1], vy[2]), YMAX);
          ymax  <= clip(max3(vy[0], vy[1], vy[2]), YMAX);
          // Clipping alone cannot express a fully off-screen box.
          empty <= (max3(vx[0], vx[1], vx[2]) < coord_t'(0))
                || (min3(vx[0], vx[1], vx[2]) > XMAX)
                || (max3(vy[0], vy[1], vy[2]) < coord_t'(0))
                || (min3(vy[0], vy[1], vy[2]) > YMAX);
          for (int k = 0; k < 3; k++) begin
            dx[k] <= diff(vy[(k+2)%3], vy[(k+1)%3]);
            dy[k] <= diff(vx[(k+1)%3], vx[(k+2)%3]);
          end
          state <= SETUP1;
        end
        SETUP1: begin
          for (int k = 0; k < 3; k++) begin
            e_raw[k] <=
              sx(diff(xmin, vx[(k+1)%3])) * sx(dx[k]) +
              sx(diff(ymin, vy[(k+1)%3])) * sx(dy[k]);
          end
          area_raw <=
            sx(diff(vx[2], vx[0])) * sx(dx[2]) +
            sx(diff(vy[2], vy[0])) * sx(dy[2]);
          state <= SETUP2;
        end
        SETUP2: begin
          area_q <= neg ? -area_raw[FIXPT_SIZE-1:0]
                        :  area_raw[FIXPT_SIZE-1:0];
          x_cur  <= xmin;
          y_cur  <= ymin;
          if (reject) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end else begin
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!bus.i_stall) begin
            bus.o_write_enable <= ~|e_neg;
            bus.o_x    <= x_cur;
            bus.o_y    <= y_cur;
            bus.o_area <= area_q;
            bus.o_e1   <= e_val[0];
            bus.o_e2   <= e_val[1];
            bus.o_e3   <= e_val[2];
            if (at_x) begin
              if (at_y) begin
                state <= DRAIN;
              end else begin
                x_cur <= xmin;
                y_cur <= y_cur + 16'sd1;
              end
            end else begin
              x_cur <= x_cur + 16'sd1;
            end
          end
        end
        DRAIN: begin
          bus.o_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_pipeline_ex0.sv
// Directed and randomized triangles checked
// against a per-pixel edge-function model.
module tb_raster_pipeline_ex0;
  import raster_pipeline_ex0_pkg::*;

  localparam int W = 320;
  localparam int H = 240;

  logic clk = 1'b0;
  logic rst = 1'b1;

  raster_pipeline_ex0_if bus();

  raster_pipeline_ex0 #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .ACC_W    (34)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int     x;
    int     y;
    longint e1;
    longint e2;
    longint e3;
    longint area;
  } pix_t;

  pix_t expq [$];

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic longint ef(
    input longint ax, input longint ay,
    input longint bx, input longint by,
    input longint px, input longint py
  );
    return (px - ax) * (by - ay) - (py - ay) * (bx - ax);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic attr_t rand_attr();
    attr_t a;
    a.r = 8'($urandom);
    a.g = 8'($urandom);
    a.b = 8'($urandom);
    a.u = $urandom;
    a.v = $urandom;
    return a;
  endfunction

  // Called at a negedge; returns at the negedge after o_done.
  task automatic run_tri(
    input int ax, input int ay,
    input int bx, input int by,
    input int cx, input int cy,
    input int stall_at, input int stall_len,
    input bit rand_stall,
    input int rst_at,
    input bit poke
  );
    longint area, s, e1, e2, e3;
    int xlo, xhi, ylo, yhi, n, limit;
    int cyc, got, done_cyc, consumed, stalls;
    bit rej, busy_ok, aborted, quiet, st;
    attr_t a1, a2, a3;
    pix_t p;

    area = ef(ax, ay, bx, by, cx, cy);
    s    = (area < 0) ? -1 : 1;
    xlo  = imax(0, imin(ax, imin(bx, cx)));
    xhi  = imin(W-1, imax(ax, imax(bx, cx)));
    ylo  = imax(0, imin(ay, imin(by, cy)));
    yhi  = imin(H-1, imax(ay, imax(by, cy)));
    rej  = (area == 0) || (xlo > xhi) || (ylo > yhi);
    n    = rej ? 0 : (xhi - xlo + 1) * (yhi - ylo + 1);
    expq.delete();
    if (!rej) begin
      for (int y = ylo; y <= yhi; y++) begin
        for (int x = xlo; x <= xhi; x++) begin
          e1 = s * ef(bx, by, cx, cy, x, y);
          e2 = s * ef(cx, cy, ax, ay, x, y);
          e3 = s * ef(ax, ay, bx, by, x, y);
          if (e1 >= 0 && e2 >= 0 && e3 >= 0)
            expq.push_back('{x, y, e1, e2, e3, s * area});
        end
      end
    end

    a1 = rand_attr();
    a2 = rand_attr();
    a3 = rand_attr();
    bus.i_v1  = '{x: coord_t'(ax), y: coord_t'(ay), attr: a1};
    bus.i_v2  = '{x: coord_t'(bx), y: coord_t'(by), attr: a2};
    bus.i_v3  = '{x: coord_t'(cx), y: coord_t'(cy), attr: a3};
    bus.i_start = 1'b1;
    bus.i_stall = 1'b0;

    cyc = 0; got = 0; done_cyc = -1;
    consumed = 0; stalls = 0;
    busy_ok = 1'b1; aborted = 1'b0;
    limit = 2 * n + 80;

    while (done_cyc < 0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      bus.i_start = poke && (cyc % 7 == 2) && (cyc < n);
      if (poke) bus.i_v1.x = coord_t'($urandom_range(0, 50));
      if (rst_at > 0 && cyc == rst_at) begin
        bus.i_stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.o_busy, 0);
        check("rst_we", bus.o_write_enable, 0);
        check("rst_x", bus.o_x, 0);
        check("rst_e1", bus.o_e1, 0);
        check("rst_v1", bus.o_v1, 0);
        quiet = 1'b1;
        repeat (6) begin
          if (bus.o_done || bus.o_busy) quiet = 1'b0;
          @(negedge clk);
        end
        check("rst_no_done", quiet, 1);
        aborted = 1'b1;
        break;
      end
      if (cyc == 1) begin
        check("attr_v1", bus.o_v1, a1);
        check("attr_v2", bus.o_v2, a2);
        check("attr_v3", bus.o_v3, a3);
      end
      if (!bus.o_busy) busy_ok = 1'b0;
      if (bus.o_write_enable) begin
        got++;
        if (got <= expq.size()) begin
          p = expq[got-1];
          check("pix_x", bus.o_x, p.x);
          check("pix_y", bus.o_y, p.y);
          check("pix_e1", bus.o_e1, p.e1);
          check("pix_e2", bus.o_e2, p.e2);
          check("pix_e3", bus.o_e3, p.e3);
          check("pix_area", bus.o_area, p.area);
          check("pix_esum",
                64'(bus.o_e1) + 64'(bus.o_e2) + 64'(bus.o_e3),
                p.area);
        end
      end
      if (bus.o_done) done_cyc = cyc;
      st = 1'b0;
      if (cyc < 4) begin
        st = rand_stall && ($urandom_range(0, 1) == 0);
      end else if (!rej && consumed < n) begin
        st = (stall_at > 0 && cyc >= stall_at &&
              cyc < stall_at + stall_len) ||
             (rand_stall && $urandom_range(0, 3) == 0);
        if (st) stalls++;
        else consumed++;
      end
      bus.i_stall = st;
    end

    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    if (!aborted) begin
      check("done_cycle", done_cyc,
            rej ? 4 : 5 + n + stalls);
      check("strobes", got, expq.size());
      check("busy_held", busy_ok, 1);
      @(negedge clk);
      check("busy_after", bus.o_busy, 0);
    end
  endtask

  initial begin
    int bx0, by0;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_v1 = '0;
    bus.i_v2 = '0;
    bus.i_v3 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    check("reset_we", bus.o_write_enable, 0);
    check("reset_xy", {bus.o_x, bus.o_y}, 0);
    check("reset_area", bus.o_area, 0);
    check("reset_v1", bus.o_v1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_tri(0, 0, 4, 0, 0, 4, 0, 0, 0, 0, 0);
    run_tri(0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0);
    run_tri(0, 0, 2, 2, 4, 4, 0, 0, 0, 0, 0);
    run_tri(1, 1, 5, 2, 2, 6, 0, 0, 0, 0, 0);
    run_tri(300, 200, 400, 200, 300, 260,
            0, 0, 0, 0, 0);
    run_tri(500, 500, 510, 500, 500, 510,
            0, 0, 0, 0, 0);
    run_tri(0, 0, 4, 0, 0, 4, 6, 3, 0, 0, 0);
    run_tri(0, 0, 4, 0, 0, 4, 0, 0, 0, 10, 0);
    run_tri(0, 0, 4, 0, 0, 4, 0, 0, 0, 0, 1);

    for (int t = 0; t < 8; t++) begin
      bx0 = (t % 2 == 1) ? 290 : 0;
      by0 = (t % 2 == 1) ? 210 : 0;
      run_tri(bx0 + $urandom_range(0, 40),
              by0 + $urandom_range(0, 40),
              bx0 + $urandom_range(0, 40),
              by0 + $urandom_range(0, 40),
              bx0 + $urandom_range(0, 40),
              by0 + $urandom_range(0, 40),
              0, 0, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
